// File: rtl/uart_spi_mc_master.sv
// SPI master with up to NUM_CS chip selects, driven by a framed UART byte stream
// (header, length, payload). Every MISO byte is returned on a valid/ready stream.
module uart_spi_mc_master #(
    parameter int NUM_CS  = 4,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NUM_CS-1:0] spi_csb,
    output logic              spi_sck,
    output logic              spi_sdi,
    input  logic              spi_sdo,
    output logic              busy,
    output logic              err
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE, LEN, SETUP, LOAD, SHIFT, HOLD, DLEN, DISCARD
    } state_t;

    state_t            state_q, state_d;
    logic [NUM_CS-1:0] csb_q, csb_d;
    logic              sck_q, sck_d;
    logic              sdi_q, sdi_d;
    logic              samp_q, samp_d;
    logic              cpha_q, cpha_d;
    logic [5:0]        cs_idx_q, cs_idx_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              err_q, err_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [3:0]        half_q, half_d;

    logic [NUM_CS-1:0] cs_sel;
    logic              in_fire;
    logic              out_fire;
    logic              div_end;
    logic              hdr_bad;
    logic [7:0]        rx_byte;

    generate
        for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_sel
            assign cs_sel[gi] = (cs_idx_q == 6'(gi));
        end
    endgenerate

    // LOAD only takes a new byte when the single output slot is (or is becoming) free.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            IDLE, LEN, DLEN, DISCARD: in_ready = rst_n;
            LOAD:                     in_ready = rst_n & (~out_valid_q | out_ready);
            default:                  in_ready = 1'b0;
        endcase
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid_q & out_ready;
    assign div_end  = (div_q == DIV_LAST);
    assign hdr_bad  = ({1'b0, in_data[5:0]} >= 7'(NUM_CS));
    // CPHA=1 samples on the trailing edge itself; CPHA=0 uses the bit caught on the leading edge.
    assign rx_byte  = cpha_q ? {shift_q[6:0], spi_sdo} : {shift_q[6:0], samp_q};

    always_comb begin
        state_d     = state_q;
        csb_d       = csb_q;
        sck_d       = sck_q;
        sdi_d       = sdi_q;
        samp_d      = samp_q;
        cpha_d      = cpha_q;
        cs_idx_d    = cs_idx_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;
        div_d       = div_q;
        half_d      = half_q;

        if (out_fire) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    cpha_d   = in_data[6];
                    cs_idx_d = in_data[5:0];
                    if (hdr_bad) begin
                        err_d   = 1'b1;
                        state_d = DLEN;
                    end else begin
                        // All CS are high here, so the idle level may follow the new CPOL.
                        sck_d   = in_data[7];
                        state_d = LEN;
                    end
                end
            end
            LEN: begin
                if (in_fire) begin
                    cnt_d   = in_data;
                    div_d   = '0;
                    csb_d   = ~cs_sel;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (div_end) begin
                    div_d   = '0;
                    state_d = LOAD;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            LOAD: begin
                if (in_fire) begin
                    shift_d = in_data;
                    sdi_d   = in_data[7];
                    div_d   = '0;
                    half_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (div_end) begin
                    div_d  = '0;
                    half_d = half_q + 4'd1;
                    sck_d  = ~sck_q;
                    if (!half_q[0]) begin
                        if (cpha_q) begin
                            sdi_d = shift_q[7];
                        end else begin
                            samp_d = spi_sdo;
                        end
                    end else begin
                        shift_d = rx_byte;
                        if (!cpha_q) begin
                            sdi_d = shift_q[6];
                        end
                    end
                    if (half_q == 4'd15) begin
                        out_data_d  = rx_byte;
                        out_valid_d = 1'b1;
                        if (cnt_q == 8'd0) begin
                            state_d = HOLD;
                        end else begin
                            cnt_d   = cnt_q - 8'd1;
                            state_d = LOAD;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            HOLD: begin
                if (div_end) begin
                    div_d   = '0;
                    csb_d   = '1;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DLEN: begin
                if (in_fire) begin
                    cnt_d   = in_data;
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (in_fire) begin
                    if (cnt_q == 8'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            csb_q       <= '1;
            sck_q       <= 1'b0;
            sdi_q       <= 1'b0;
            samp_q      <= 1'b0;
            cpha_q      <= 1'b0;
            cs_idx_q    <= '0;
            cnt_q       <= '0;
            shift_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            div_q       <= '0;
            half_q      <= '0;
        end else begin
            state_q     <= state_d;
            csb_q       <= csb_d;
            sck_q       <= sck_d;
            sdi_q       <= sdi_d;
            samp_q      <= samp_d;
            cpha_q      <= cpha_d;
            cs_idx_q    <= cs_idx_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            div_q       <= div_d;
            half_q      <= half_d;
        end
    end

    assign spi_csb   = csb_q;
    assign spi_sck   = sck_q;
    assign spi_sdi   = sdi_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_spi_mc_master.sv
// Directed bench for uart_spi_mc_master: main instance NUM_CS=4/CLK_DIV=4,
// second instance with CLK_DIV=1 for the 256-byte frame.
module tb_uart_spi_mc_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] spi_csb;
    logic       spi_sck;
    logic       spi_sdi;
    logic       spi_sdo;
    logic       busy;
    logic       err;

    logic [7:0] d1_in_data;
    logic       d1_in_valid;
    logic       d1_in_ready;
    logic [7:0] d1_out_data;
    logic       d1_out_valid;
    logic       d1_out_ready;
    logic [3:0] d1_spi_csb;
    logic       d1_spi_sck;
    logic       d1_spi_sdi;
    logic       d1_spi_sdo;
    logic       d1_busy;
    logic       d1_err;

    int tests_run = 0;
    int failures  = 0;

    uart_spi_mc_master #(.NUM_CS(4), .CLK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .spi_csb(spi_csb), .spi_sck(spi_sck), .spi_sdi(spi_sdi), .spi_sdo(spi_sdo),
        .busy(busy), .err(err)
    );

    uart_spi_mc_master #(.NUM_CS(4), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_data(d1_in_data), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .out_data(d1_out_data), .out_valid(d1_out_valid), .out_ready(d1_out_ready),
        .spi_csb(d1_spi_csb), .spi_sck(d1_spi_sck), .spi_sdi(d1_spi_sdi), .spi_sdo(d1_spi_sdo),
        .busy(d1_busy), .err(d1_err)
    );

    // Slave: either MOSI looped back, or a fixed pattern shifted out on each falling SCK edge.
    logic       loopback  = 1'b1;
    logic [7:0] slave_pat = 8'h00;
    logic       slave_sdo = 1'b0;
    logic [2:0] fcnt      = 3'd0;
    logic       prev_sck  = 1'b0;
    assign spi_sdo    = loopback ? spi_sdi : slave_sdo;
    assign d1_spi_sdo = d1_spi_sdi;

    always @(negedge clk) begin
        if (&spi_csb) begin
            fcnt <= 3'd0;
        end else if (prev_sck && !spi_sck) begin
            slave_sdo <= slave_pat[3'd7 - fcnt];
            fcnt      <= fcnt + 3'd1;
        end
        prev_sck <= spi_sck;
    end

    int rise_cnt    = 0;
    int tog_cnt     = 0;
    int err_cnt     = 0;
    int csb_low_cnt = 0;
    int d1_cnt      = 0;
    int d1_bad      = 0;
    logic [7:0] outq[$];

    always @(posedge spi_sck) if (spi_csb != 4'hF) rise_cnt <= rise_cnt + 1;
    always @(spi_sck) tog_cnt <= tog_cnt + 1;

    always @(negedge clk) begin
        #1;
        if (out_valid && out_ready) outq.push_back(out_data);
        if (err) err_cnt <= err_cnt + 1;
        if (spi_csb != 4'hF) csb_low_cnt <= csb_low_cnt + 1;
        if (d1_out_valid && d1_out_ready) begin
            if (d1_out_data != 8'(d1_cnt)) d1_bad <= d1_bad + 1;
            d1_cnt <= d1_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            tests_run++;
            failures++;
            $display("FAIL send_timeout: byte %02h in_ready=%b, required 1", b, in_ready);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(output int n);
        n = 0;
        while (!out_valid && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        d1_in_valid = 1'b0; d1_in_data = 8'h00; d1_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (spi_csb !== 4'hF) begin failures++; $display("FAIL rst_csb: got %b, required 1111", spi_csb); end
        tests_run++; if (spi_sck !== 1'b0) begin failures++; $display("FAIL rst_sck: got %b, required 0", spi_sck); end
        tests_run++; if (spi_sdi !== 1'b0) begin failures++; $display("FAIL rst_sdi: got %b, required 0", spi_sdi); end
        tests_run++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        tests_run++; if (out_data !== 8'h00) begin failures++; $display("FAIL rst_out_data: got %02h, required 00", out_data); end
        tests_run++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
        tests_run++; if (busy !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rst_busy_err: got %b%b, required 00", busy, err); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests_run++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL idle_ready: got in_ready=%b busy=%b, required 1 0", in_ready, busy); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_mode0;
        int n, r0;
        loopback = 1'b1; out_ready = 1'b1;
        send(8'h01);
        send(8'h00);
        r0 = rise_cnt;
        send(8'hA5);
        wait_out_valid(n);
        tests_run++; if (n + 1 != 65) begin failures++; $display("FAIL mode0_latency: got %0d cycles, required 65", n + 1); end
        tests_run++; if (out_data !== 8'hA5) begin failures++; $display("FAIL mode0_data: got %02h, required a5", out_data); end
        tests_run++; if (spi_csb !== 4'b1101) begin failures++; $display("FAIL mode0_csb: got %b, required 1101", spi_csb); end
        tests_run++; if (rise_cnt - r0 != 8) begin failures++; $display("FAIL mode0_rises: got %0d, required 8", rise_cnt - r0); end
        repeat (3) begin @(posedge clk); #1; end
        tests_run++; if (spi_csb !== 4'b1101) begin failures++; $display("FAIL mode0_hold: got %b, required 1101", spi_csb); end
        @(posedge clk);
        #1;
        tests_run++; if (spi_csb !== 4'hF || busy !== 1'b0) begin failures++; $display("FAIL mode0_release: got csb=%b busy=%b, required 1111 0", spi_csb, busy); end
        $display("[TB] test_mode0 payload a5 -> %02h in %0d cycles", out_data, n + 1);
    endtask

    task automatic test_mode3;
        int n, q0;
        q0 = outq.size();
        loopback = 1'b0; slave_pat = 8'h3C; out_ready = 1'b1;
        send(8'hC2);
        tests_run++; if (spi_sck !== 1'b1) begin failures++; $display("FAIL mode3_sck_idle: got %b, required 1", spi_sck); end
        send(8'h01);
        send(8'h12);
        wait_out_valid(n);
        tests_run++; if (spi_csb !== 4'b1011) begin failures++; $display("FAIL mode3_csb0: got %b, required 1011", spi_csb); end
        send(8'h34);
        wait_out_valid(n);
        tests_run++; if (spi_csb !== 4'b1011) begin failures++; $display("FAIL mode3_csb1: got %b, required 1011", spi_csb); end
        repeat (8) begin @(posedge clk); #1; end
        tests_run++; if (outq.size() - q0 != 2) begin failures++; $display("FAIL mode3_count: got %0d, required 2", outq.size() - q0); end
        else begin
            tests_run++; if (outq[q0] !== 8'h3C || outq[q0+1] !== 8'h3C) begin failures++; $display("FAIL mode3_data: got %02h %02h, required 3c 3c", outq[q0], outq[q0+1]); end
        end
        tests_run++; if (spi_sck !== 1'b1 || spi_csb !== 4'hF) begin failures++; $display("FAIL mode3_end: got sck=%b csb=%b, required 1 1111", spi_sck, spi_csb); end
        $display("[TB] test_mode3 frame of 2 bytes, slave 3c");
    endtask

    task automatic test_invalid;
        int n, e0, t0, c0, q0;
        loopback = 1'b1; out_ready = 1'b1;
        e0 = err_cnt; t0 = tog_cnt; c0 = csb_low_cnt; q0 = outq.size();
        send(8'h05);
        tests_run++; if (err !== 1'b1) begin failures++; $display("FAIL inv_err: got %b, required 1", err); end
        send(8'h02);
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        @(posedge clk);
        #1;
        tests_run++; if (busy !== 1'b0) begin failures++; $display("FAIL inv_busy: got %b, required 0", busy); end
        tests_run++; if (err_cnt - e0 != 1) begin failures++; $display("FAIL inv_err_len: got %0d cycles, required 1", err_cnt - e0); end
        tests_run++; if (tog_cnt != t0 || csb_low_cnt != c0) begin failures++; $display("FAIL inv_spi_quiet: got toggles=%0d csb_low=%0d, required 0 0", tog_cnt - t0, csb_low_cnt - c0); end
        tests_run++; if (outq.size() != q0) begin failures++; $display("FAIL inv_no_out: got %0d bytes, required 0", outq.size() - q0); end
        send(8'h00);
        send(8'h00);
        send(8'h5A);
        wait_out_valid(n);
        tests_run++; if (out_data !== 8'h5A || spi_csb !== 4'b1110) begin failures++; $display("FAIL inv_next_frame: got %02h csb=%b, required 5a 1110", out_data, spi_csb); end
        repeat (6) begin @(posedge clk); #1; end
        $display("[TB] test_invalid header 05 discarded 3 bytes");
    endtask

    task automatic test_back_to_back;
        int n, q0, t0;
        loopback = 1'b1; out_ready = 1'b0;
        q0 = outq.size();
        send(8'h01);
        send(8'h01);
        send(8'h11);
        @(negedge clk);
        in_data = 8'h22; in_valid = 1'b1;
        wait_out_valid(n);
        repeat (10) begin @(posedge clk); #1; end
        t0 = tog_cnt;
        tests_run++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
        tests_run++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin failures++; $display("FAIL bp_hold_out: got valid=%b data=%02h, required 1 11", out_valid, out_data); end
        tests_run++; if (spi_sck !== 1'b0 || spi_csb !== 4'b1101) begin failures++; $display("FAIL bp_idle_bus: got sck=%b csb=%b, required 0 1101", spi_sck, spi_csb); end
        repeat (10) begin @(posedge clk); #1; end
        tests_run++; if (tog_cnt != t0) begin failures++; $display("FAIL bp_sck_still: got %0d toggles, required 0", tog_cnt - t0); end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b, required 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out_valid(n);
        tests_run++; if (n + 1 != 65) begin failures++; $display("FAIL bp_second_latency: got %0d, required 65", n + 1); end
        repeat (8) begin @(posedge clk); #1; end
        tests_run++; if (outq.size() - q0 != 2) begin failures++; $display("FAIL bp_count: got %0d, required 2", outq.size() - q0); end
        else begin
            tests_run++; if (outq[q0] !== 8'h11 || outq[q0+1] !== 8'h22) begin failures++; $display("FAIL bp_order: got %02h %02h, required 11 22", outq[q0], outq[q0+1]); end
        end
        $display("[TB] test_back_to_back delivered %0d bytes after release", outq.size() - q0);
    endtask

    task automatic test_reset_mid_shift;
        int n, q0, t0;
        loopback = 1'b1; out_ready = 1'b1;
        q0 = outq.size();
        send(8'h00);
        send(8'h00);
        t0 = tog_cnt;
        send(8'hFF);
        n = 0;
        while (tog_cnt - t0 < 5 && n < 500) begin @(negedge clk); n++; end
        tests_run++; if (tog_cnt - t0 != 5) begin failures++; $display("FAIL mid_edges: got %0d, required 5", tog_cnt - t0); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tests_run++; if (spi_csb !== 4'hF || spi_sck !== 1'b0) begin failures++; $display("FAIL mid_rst_bus: got csb=%b sck=%b, required 1111 0", spi_csb, spi_sck); end
        tests_run++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_rst_state: got valid=%b busy=%b, required 0 0", out_valid, busy); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        tests_run++; if (outq.size() != q0) begin failures++; $display("FAIL mid_partial_lost: got %0d bytes, required 0", outq.size() - q0); end
        send(8'h03);
        send(8'h00);
        send(8'h96);
        wait_out_valid(n);
        tests_run++; if (out_data !== 8'h96 || spi_csb !== 4'b0111) begin failures++; $display("FAIL mid_fresh_frame: got %02h csb=%b, required 96 0111", out_data, spi_csb); end
        repeat (6) begin @(posedge clk); #1; end
        $display("[TB] test_reset_mid_shift fresh frame -> 96");
    endtask

    task automatic test_clkdiv1;
        int n, sent;
        logic [7:0] b;
        sent = 0;
        d1_out_ready = 1'b1;
        for (int i = 0; i < 258; i++) begin
            b = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'(i - 2);
            @(negedge clk);
            d1_in_data = b; d1_in_valid = 1'b1;
            #1;
            n = 0;
            while (!d1_in_ready && n < 200) begin @(negedge clk); #1; n++; end
            if (!d1_in_ready) break;
            @(posedge clk);
            #1;
            d1_in_valid = 1'b0;
            sent++;
        end
        d1_in_valid = 1'b0;
        repeat (100) begin @(posedge clk); #1; end
        tests_run++; if (sent != 258) begin failures++; $display("FAIL div1_sent: got %0d bytes accepted, required 258", sent); end
        tests_run++; if (d1_cnt != 256) begin failures++; $display("FAIL div1_count: got %0d outputs, required 256", d1_cnt); end
        tests_run++; if (d1_bad != 0) begin failures++; $display("FAIL div1_data: got %0d wrong bytes, required 0", d1_bad); end
        tests_run++; if (d1_busy !== 1'b0 || d1_spi_csb !== 4'hF) begin failures++; $display("FAIL div1_end: got busy=%b csb=%b, required 0 1111", d1_busy, d1_spi_csb); end
        $display("[TB] test_clkdiv1 %0d outputs", d1_cnt);
    endtask

    initial begin
        test_reset;
        test_mode0;
        test_mode3;
        test_invalid;
        test_back_to_back;
        test_reset_mid_shift;
        test_clkdiv1;
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
